// File: rtl/alu_operand_pipe.sv
// alu_operand_pipe: selects and formats one of NSRC source words and presents it
// through a valid/ready register with a two-entry skid buffer and synchronous flush.
module alu_operand_pipe #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 4,
    parameter int SHAMT_W = 5,
    parameter int IMM_W   = 16,
    localparam int SEL_W  = $clog2(NSRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NSRC*WIDTH-1:0]   in_src,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_z,
    output logic                    out_err
);
    logic [WIDTH-1:0] s, f_z;
    logic             f_e, accept, pop;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_z_q, main_z_d, skid_z_q, skid_z_d;
    logic             main_e_q, main_e_d, skid_e_q, skid_e_d;

    // An out-of-range select falls through to source 0 and flags the error.
    always_comb begin
        s   = in_src[WIDTH-1:0];
        f_e = 1'b1;
        for (int k = 0; k < NSRC; k++)
            if (int'(in_sel) == k) begin
                s   = in_src[k*WIDTH +: WIDTH];
                f_e = 1'b0;
            end
        f_z = in_mode == 2'b00 ? s :
              in_mode == 2'b01 ? WIDTH'(s[SHAMT_W-1:0]) :
              in_mode == 2'b10 ? WIDTH'($signed(s[IMM_W-1:0])) :
                                 s << (WIDTH - IMM_W);
    end

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_z     = main_z_q;
    assign out_err   = main_e_q;
    assign accept    = in_valid & ~skid_v_q;
    assign pop       = main_v_q & out_ready;

    always_comb begin
        main_v_d = main_v_q;
        main_z_d = main_z_q;
        main_e_d = main_e_q;
        skid_v_d = skid_v_q;
        skid_z_d = skid_z_q;
        skid_e_d = skid_e_q;
        if (pop && skid_v_q) begin
            main_v_d = 1'b1;
            main_z_d = skid_z_q;
            main_e_d = skid_e_q;
            skid_v_d = accept;
            skid_z_d = f_z;
            skid_e_d = f_e;
        end else if (pop || !main_v_q) begin
            main_v_d = accept;
            main_z_d = f_z;
            main_e_d = f_e;
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_z_d = f_z;
            skid_e_d = f_e;
        end
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            main_z_q <= '0;
            main_e_q <= 1'b0;
            skid_v_q <= 1'b0;
            skid_z_q <= '0;
            skid_e_q <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            main_z_q <= main_z_d;
            main_e_q <= main_e_d;
            skid_v_q <= skid_v_d;
            skid_z_q <= skid_z_d;
            skid_e_q <= skid_e_d;
        end
    end
endmodule

// File: tb/tb_alu_operand_pipe.sv
// tb_alu_operand_pipe: table vectors, hand-written handshake sequences and random
// traffic for two instances (NSRC=4 and NSRC=3) checked against a FIFO reference model.
module tb_alu_operand_pipe;
    logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [127:0] src_bus;
    logic [1:0]   in_sel = '0, in_mode = '0;
    logic         rdy4, rdy3, ov4, ov3, oe4, oe3;
    logic [31:0]  oz4, oz3;
    int           total = 0, bad = 0;

    typedef struct {
        logic [31:0] z4;
        logic        e4;
        logic [31:0] z3;
        logic        e3;
    } exp_t;
    typedef struct {
        int          sel;
        int          mode;
        logic [31:0] z4;
        logic        e4;
        logic [31:0] z3;
        logic        e3;
    } vec_t;
    exp_t q[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    alu_operand_pipe #(.NSRC(4)) d4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
        .in_src(src_bus), .in_sel(in_sel), .in_mode(in_mode), .out_valid(ov4),
        .out_ready(out_ready), .out_z(oz4), .out_err(oe4));
    alu_operand_pipe #(.NSRC(3)) d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy3),
        .in_src(src_bus[95:0]), .in_sel(in_sel), .in_mode(in_mode), .out_valid(ov3),
        .out_ready(out_ready), .out_z(oz3), .out_err(oe3));

    function automatic logic [32:0] ref_fmt(input logic [127:0] bus, input int sel, input int nsrc, input int mode);
        logic [31:0] s, lo, z;
        logic        e;
        e  = sel >= nsrc;
        s  = e ? bus[31:0] : bus[sel*32 +: 32];
        lo = s % 65536;
        z  = mode == 0 ? s : mode == 1 ? s % 32 : mode == 2 ? (lo >= 32768 ? lo + 32'hFFFF0000 : lo) : lo * 65536;
        return {e, z};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two formatted transactions.
    always @(posedge clk) begin
        if (!rst_n || flush) q.delete();
        else begin
            automatic bit   acc = in_valid && q.size() < 2;
            automatic bit   pp  = q.size() > 0 && out_ready;
            automatic exp_t x;
            {x.e4, x.z4} = ref_fmt(src_bus, int'(in_sel), 4, int'(in_mode));
            {x.e3, x.z3} = ref_fmt(src_bus, int'(in_sel), 3, int'(in_mode));
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(x);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mon_rdy4", 32'(rdy4), 32'(q.size() < 2));
            chk("mon_rdy3", 32'(rdy3), 32'(q.size() < 2));
            chk("mon_ov4", 32'(ov4), 32'(q.size() > 0));
            chk("mon_ov3", 32'(ov3), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("mon_z4", oz4, q[0].z4);
                chk("mon_e4", 32'(oe4), 32'(q[0].e4));
                chk("mon_z3", oz3, q[0].z3);
                chk("mon_e3", 32'(oe3), 32'(q[0].e3));
            end
        end
    end

    task automatic drive(input int sel, input int mode, input logic v);
        in_sel   = 2'(sel);
        in_mode  = 2'(mode);
        in_valid = v;
    endtask

    initial begin
        tbl[0] = '{2, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1, 1, 32'h0000001C, 1'b0, 32'h0000001C, 1'b0};
        tbl[2] = '{1, 2, 32'hFFFF8ABC, 1'b0, 32'hFFFF8ABC, 1'b0};
        tbl[3] = '{1, 3, 32'h8ABC0000, 1'b0, 32'h8ABC0000, 1'b0};
        tbl[4] = '{3, 0, 32'hCAFEF00D, 1'b0, 32'h00000055, 1'b1};
        tbl[5] = '{3, 2, 32'hFFFFF00D, 1'b0, 32'h00000055, 1'b1};
        tbl[6] = '{0, 1, 32'h00000015, 1'b0, 32'h00000015, 1'b0};
        tbl[7] = '{3, 3, 32'hF00D0000, 1'b0, 32'h00550000, 1'b1};
        tbl[8] = '{2, 1, 32'h0000000F, 1'b0, 32'h0000000F, 1'b0};
        tbl[9] = '{2, 2, 32'hFFFFBEEF, 1'b0, 32'hFFFFBEEF, 1'b0};
        src_bus = {32'hCAFEF00D, 32'hDEADBEEF, 32'h12348ABC, 32'h00000055};

        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(rdy4), 32'd1);
        chk("rst_ov", 32'(ov4), 32'd0);
        chk("rst_z", oz4, 32'd0);
        chk("rst_err", 32'(oe4), 32'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk) drive(tbl[i].sel, tbl[i].mode, 1'b1);
            @(negedge clk) in_valid = 1'b0;
            chk($sformatf("tbl%0d_ov", i), 32'(ov4 & ov3), 32'd1);
            chk($sformatf("tbl%0d_z4", i), oz4, tbl[i].z4);
            chk($sformatf("tbl%0d_e4", i), 32'(oe4), 32'(tbl[i].e4));
            chk($sformatf("tbl%0d_z3", i), oz3, tbl[i].z3);
            chk($sformatf("tbl%0d_e3", i), 32'(oe3), 32'(tbl[i].e3));
        end

        // Backpressure: A and B fill the buffer, C is held until the first pop.
        @(negedge clk) out_ready = 1'b0;
        drive(2, 0, 1'b1);
        @(negedge clk) chk("bp_rdy_a", 32'(rdy4), 32'd1);
        chk("bp_z_a", oz4, 32'hDEADBEEF);
        drive(1, 2, 1'b1);
        @(negedge clk) chk("bp_rdy_ab", 32'(rdy4), 32'd0);
        drive(3, 0, 1'b1);
        @(negedge clk) chk("bp_rdy_hold", 32'(rdy4), 32'd0);
        chk("bp_stable", oz4, 32'hDEADBEEF);
        out_ready = 1'b1;
        @(negedge clk) chk("bp_z_b", oz4, 32'hFFFF8ABC);
        chk("bp_rdy_up", 32'(rdy4), 32'd1);
        @(negedge clk) in_valid = 1'b0;
        chk("bp_z_c", oz4, 32'hCAFEF00D);
        chk("bp_ov_c", 32'(ov4), 32'd1);
        @(negedge clk) chk("bp_empty", 32'(ov4), 32'd0);

        // Flush with two entries buffered and a valid input D in the same cycle.
        out_ready = 1'b0;
        drive(2, 0, 1'b1);
        @(negedge clk) drive(1, 0, 1'b1);
        @(negedge clk) drive(0, 0, 1'b1);
        flush = 1'b1;
        @(negedge clk) flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("fl_ov", 32'(ov4), 32'd0);
        chk("fl_rdy", 32'(rdy4), 32'd1);
        for (int i = 0; i < 3; i++) @(negedge clk) chk("fl_no_d", 32'(ov4 | ov3), 32'd0);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            src_bus   = {$urandom, $urandom, $urandom, $urandom};
            drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 2) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = $urandom_range(0, 24) == 0;
        end
        @(negedge clk) drive(0, 0, 1'b0);
        flush = 1'b0;
        out_ready = 1'b0;

        // Asynchronous reset while an entry is on the output.
        drive(2, 0, 1'b1);
        @(negedge clk) in_valid = 1'b0;
        chk("ar_pre_ov", 32'(ov4), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("ar_ov", 32'(ov4 | ov3), 32'd0);
        chk("ar_z", oz4, 32'd0);
        chk("ar_rdy", 32'(rdy4 & rdy3), 32'd1);
        @(negedge clk) #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
